plab3_proc_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end. It sits between the pipelined core's F stage and the instruction-memory port.
- It replaces the fixed one-deep drop-unit plus 2-entry bypass-queue arrangement.
- It sequentially prefetches up to p_max_inflight instructions, buffers their responses and delivers {pc, inst} to the core over val/rdy.
- On a redirect it squashes all buffered and in-flight fetches by counting stale responses and dropping them.

---
 rtl/plab3_proc_fetch_unit.sv | 111 +++++++++++
 tb/tb_plab3_proc_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab3_proc_fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential prefetch into a circular
// response buffer, with redirect squash implemented by counting stale responses.
module plab3_proc_fetch_unit #(
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_max_inflight = 4,
  parameter logic [p_addr_nbits-1:0] p_reset_vector = p_addr_nbits'(32'h1000),
  parameter int unsigned p_inst_bytes   = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  redirect_val,
  input  logic [p_addr_nbits-1:0]               redirect_pc,
  output logic                                  imemreq_val,
  input  logic                                  imemreq_rdy,
  output logic [p_addr_nbits-1:0]               imemreq_addr,
  output logic [p_opaque_nbits-1:0]             imemreq_opaque,
  input  logic                                  imemresp_val,
  output logic                                  imemresp_rdy,
  input  logic [p_data_nbits-1:0]               imemresp_data,
  output logic                                  inst_val,
  input  logic                                  inst_rdy,
  output logic [p_data_nbits-1:0]               inst_data,
  output logic [p_addr_nbits-1:0]               inst_pc,
  output logic [$clog2(p_max_inflight+1)-1:0]   inflight,
  output logic                                  squashing
);

  localparam int unsigned CNT_W = $clog2(p_max_inflight + 1);
  localparam int unsigned PTR_W = $clog2(p_max_inflight);
  localparam logic [CNT_W:0] MAX_OCC = (CNT_W + 1)'(p_max_inflight);
  localparam logic [p_addr_nbits-1:0] PC_INC = p_addr_nbits'(p_inst_bytes);

  logic [p_addr_nbits-1:0]   fetch_pc;
  logic [p_addr_nbits-1:0]   out_pc;
  logic [p_opaque_nbits-1:0] seq;
  logic [CNT_W-1:0]          drop_cnt;
  logic [CNT_W-1:0]          count;
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [p_data_nbits-1:0]   buf_mem [p_max_inflight];

  logic           req_fire;
  logic           resp_fire;
  logic           resp_keep;
  logic           inst_fire;
  logic [CNT_W:0] occupancy;

  // Handshakes and outputs; credits count both outstanding requests and buffered responses
  always_comb begin
    occupancy      = {1'b0, inflight} + {1'b0, count};
    imemreq_val    = reset && !redirect_val && (occupancy < MAX_OCC);
    imemreq_addr   = fetch_pc;
    imemreq_opaque = seq;
    imemresp_rdy   = reset;
    inst_val       = reset && (count != '0);
    inst_data      = buf_mem[head];
    inst_pc        = out_pc;
    squashing      = (drop_cnt != '0);
    req_fire       = imemreq_val && imemreq_rdy;
    resp_fire      = reset && imemresp_val;
    resp_keep      = resp_fire && (drop_cnt == '0) && !redirect_val;
    inst_fire      = inst_val && inst_rdy && !redirect_val;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= p_reset_vector;
      out_pc   <= p_reset_vector;
      seq      <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_fire);
      if (redirect_val) begin
        fetch_pc <= redirect_pc;
        out_pc   <= redirect_pc;
        // Everything still outstanding after this cycle is stale, earlier squashes included
        drop_cnt <= inflight - CNT_W'(resp_fire);
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_INC;
          seq      <= seq + p_opaque_nbits'(1);
        end
        if (resp_fire && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CNT_W'(1);
        if (resp_keep)
          tail <= tail + PTR_W'(1);
        if (inst_fire) begin
          head   <= head + PTR_W'(1);
          out_pc <= out_pc + PC_INC;
        end
        count <= count + CNT_W'(resp_keep) - CNT_W'(inst_fire);
      end
    end
  end

  // Response storage needs no reset: entries are only read while count says they are valid
  always_ff @(posedge clk) begin
    if (resp_keep)
      buf_mem[tail] <= imemresp_data;
  end

endmodule

// File: tb/tb_plab3_proc_fetch_unit.sv
// Self-checking bench for plab3_proc_fetch_unit: directed vector table, hand-written
// redirect/reset sequences and randomized traffic against a queue-based reference model.
module tb_plab3_proc_fetch_unit;

  localparam int MAXI = 4;

  logic        clk;
  logic        reset;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic [7:0]  imemreq_opaque;
  logic        imemresp_val;
  logic        imemresp_rdy;
  logic [31:0] imemresp_data;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  inflight;
  logic        squashing;

  plab3_proc_fetch_unit dut (
    .clk(clk), .reset(reset),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemreq_addr(imemreq_addr), .imemreq_opaque(imemreq_opaque),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .imemresp_data(imemresp_data),
    .inst_val(inst_val), .inst_rdy(inst_rdy),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .inflight(inflight), .squashing(squashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory model: in-order responses, each no earlier than its due cycle
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  bit    mem_hold = 1'b0;
  int    cur_lat  = 1;
  int    cyc      = 0;

  // Reference model: outstanding requests (stale flag) and buffered instruction words
  bit          outq[$];
  logic [31:0] bufq[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_out_pc;
  logic [7:0]  m_seq;

  logic        s_req_val, s_inst_val, s_squashing;
  logic [31:0] s_addr, s_inst_pc, s_inst_data;
  logic [7:0]  s_opq;
  logic [2:0]  s_inflight;

  task automatic model_clear();
    outq.delete();
    bufq.delete();
    mem_q.delete();
    m_fetch_pc = 32'h1000;
    m_out_pc   = 32'h1000;
    m_seq      = 8'd0;
  endtask

  task automatic tick();
    bit          m_req_val, m_inst_val, st;
    int          nstale;
    if (reset && !mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imemresp_val  = 1'b1;
      imemresp_data = inst_of(mem_q[0].addr);
    end else begin
      imemresp_val  = 1'b0;
      imemresp_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    m_req_val  = reset && !redirect_val && ((outq.size() + bufq.size()) < MAXI);
    m_inst_val = reset && (bufq.size() != 0);
    nstale = 0;
    foreach (outq[i]) if (outq[i]) nstale++;

    s_req_val = imemreq_val;   s_addr = imemreq_addr;  s_opq = imemreq_opaque;
    s_inst_val = inst_val;     s_inst_pc = inst_pc;    s_inst_data = inst_data;
    s_inflight = inflight;     s_squashing = squashing;

    chk("req_val", 64'(imemreq_val), 64'(m_req_val));
    chk("resp_rdy", 64'(imemresp_rdy), 64'(reset));
    chk("inst_val", 64'(inst_val), 64'(m_inst_val));
    chk("inflight", 64'(inflight), 64'(outq.size()));
    chk("squashing", 64'(squashing), 64'(nstale != 0));
    if (m_req_val) begin
      chk("req_addr", 64'(imemreq_addr), 64'(m_fetch_pc));
      chk("req_opaque", 64'(imemreq_opaque), 64'(m_seq));
    end
    if (m_inst_val) begin
      chk("inst_pc", 64'(inst_pc), 64'(m_out_pc));
      chk("inst_data", 64'(inst_data), 64'(bufq[0]));
    end

    if (!reset) begin
      model_clear();
    end else begin
      if (m_inst_val && inst_rdy && !redirect_val) begin
        void'(bufq.pop_front());
        m_out_pc = m_out_pc + 32'd4;
      end
      if (imemresp_val) begin
        st = outq.pop_front();
        void'(mem_q.pop_front());
        if (!st && !redirect_val) bufq.push_back(imemresp_data);
      end
      if (redirect_val) begin
        foreach (outq[i]) outq[i] = 1'b1;
        bufq.delete();
        m_fetch_pc = redirect_pc;
        m_out_pc   = redirect_pc;
      end else if (m_req_val && imemreq_rdy) begin
        outq.push_back(1'b0);
        mem_q.push_back('{addr: m_fetch_pc, due: cyc + cur_lat});
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_seq      = m_seq + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_val = 1'b0; mem_hold = 1'b0; cur_lat = 1;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_inst(input string name, input logic [31:0] exp_pc);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (s_inst_val) got = 1'b1;
    end
    chk({name, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({name, "_pc"}, 64'(s_inst_pc), 64'(exp_pc));
      chk({name, "_data"}, 64'(s_inst_data), 64'(inst_of(exp_pc)));
    end
  endtask

  typedef struct {
    bit          inst_rdy;
    bit          exp_req_val;
    logic [31:0] exp_addr;
    int          exp_inflight;
    bit          exp_inst_val;
    logic [31:0] exp_pc;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int   n_inst;

    reset = 1'b0; redirect_val = 1'b0; redirect_pc = '0;
    imemreq_rdy = 1'b1; inst_rdy = 1'b0;
    imemresp_val = 1'b0; imemresp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    do_reset();

    // Credit limit: four requests fill the buffer, one inst_fire frees one credit
    vecs[0] = '{0, 1, 32'h1000, 0, 0, 32'h0};
    vecs[1] = '{0, 1, 32'h1004, 1, 0, 32'h0};
    vecs[2] = '{0, 1, 32'h1008, 1, 1, 32'h1000};
    vecs[3] = '{0, 1, 32'h100C, 1, 1, 32'h1000};
    vecs[4] = '{0, 0, 32'h0,    1, 1, 32'h1000};
    vecs[5] = '{0, 0, 32'h0,    0, 1, 32'h1000};
    vecs[6] = '{1, 0, 32'h0,    0, 1, 32'h1000};
    vecs[7] = '{0, 1, 32'h1010, 0, 1, 32'h1004};
    vecs[8] = '{0, 0, 32'h0,    1, 1, 32'h1004};
    for (int i = 0; i < 9; i++) begin
      inst_rdy = vecs[i].inst_rdy;
      tick();
      chk($sformatf("vec%0d_req_val", i), 64'(s_req_val), 64'(vecs[i].exp_req_val));
      if (vecs[i].exp_req_val)
        chk($sformatf("vec%0d_addr", i), 64'(s_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_inflight", i), 64'(s_inflight), 64'(vecs[i].exp_inflight));
      chk($sformatf("vec%0d_inst_val", i), 64'(s_inst_val), 64'(vecs[i].exp_inst_val));
      if (vecs[i].exp_inst_val)
        chk($sformatf("vec%0d_inst_pc", i), 64'(s_inst_pc), 64'(vecs[i].exp_pc));
    end

    // Streaming: one instruction per cycle once the pipe is full
    do_reset();
    inst_rdy = 1'b1;
    n_inst = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_inst_val) n_inst++;
    end
    chk("stream_rate", 64'(n_inst), 64'd10);

    // Redirect with three in flight and one buffered
    do_reset();
    inst_rdy = 1'b0;
    tick(); tick();
    mem_hold = 1'b1;
    tick(); tick();
    redirect_val = 1'b1; redirect_pc = 32'h2000;
    tick();
    chk("rdA_inflight", 64'(s_inflight), 64'd3);
    chk("rdA_inst_val", 64'(s_inst_val), 64'd1);
    redirect_val = 1'b0;
    tick();
    chk("rdA_squashing", 64'(s_squashing), 64'd1);
    chk("rdA_inst_flushed", 64'(s_inst_val), 64'd0);
    chk("rdA_new_addr", 64'(s_addr), 64'h2000);
    mem_hold = 1'b0;
    wait_inst("rdA_first", 32'h2000);

    // Redirect coincident with a response: exactly one later drop
    do_reset();
    inst_rdy = 1'b0;
    tick();
    mem_hold = 1'b1;
    tick();
    mem_hold = 1'b0;
    redirect_val = 1'b1; redirect_pc = 32'h5000;
    tick();
    chk("rdB_inflight", 64'(s_inflight), 64'd2);
    redirect_val = 1'b0;
    tick();
    chk("rdB_squash_on", 64'(s_squashing), 64'd1);
    chk("rdB_addr", 64'(s_addr), 64'h5000);
    tick();
    chk("rdB_squash_off", 64'(s_squashing), 64'd0);
    wait_inst("rdB_first", 32'h5000);

    // Back-to-back redirects while memory stalls: last target wins
    do_reset();
    inst_rdy = 1'b0; imemreq_rdy = 1'b0;
    redirect_val = 1'b1; redirect_pc = 32'h3000;
    tick();
    chk("rdC_no_req0", 64'(s_req_val), 64'd0);
    redirect_pc = 32'h4000;
    tick();
    chk("rdC_no_req1", 64'(s_req_val), 64'd0);
    redirect_val = 1'b0;
    tick();
    chk("rdC_stall_addr", 64'(s_addr), 64'h4000);
    imemreq_rdy = 1'b1;
    tick();
    chk("rdC_stable_addr", 64'(s_addr), 64'h4000);
    wait_inst("rdC_first", 32'h4000);

    // Reset mid-stream with two buffered
    do_reset();
    inst_rdy = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_inst_val", 64'(s_inst_val), 64'd0);
    chk("rst_req_val", 64'(s_req_val), 64'd0);
    reset = 1'b1;
    tick();
    chk("rst_inflight", 64'(s_inflight), 64'd0);
    chk("rst_inst_val_after", 64'(s_inst_val), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'h1000);
    chk("rst_opaque", 64'(s_opq), 64'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) != 0);
      redirect_val = ($urandom_range(0, 15) == 0);
      redirect_pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      imemreq_rdy  = ($urandom_range(0, 3) != 0);
      inst_rdy     = ($urandom_range(0, 9) < 7);
      cur_lat      = $urandom_range(1, 4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
